// File: rtl/palette_ctrl.sv
// rtl/palette_ctrl.sv - double-buffered 8-entry palette with vblank commit and icon blink
module palette_ctrl #(
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       commit,
  input  logic       frame_start,
  output logic       pending,
  input  logic       video_on,
  input  logic [1:0] wall,
  input  logic [1:0] icon,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_COPY    = 2'd2
  } state_t;

  localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       commit_q, commit_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       blink_q, blink_d;
  logic [7:0] rgb_q, rgb_d;

  logic [7:0] shadow_q [8];
  logic [7:0] active_q [8];

  function automatic logic [7:0] reset_entry(input logic [2:0] i);
    case (i)
      3'd0:    reset_entry = 8'hFF;
      3'd1:    reset_entry = 8'h1C;
      3'd2:    reset_entry = 8'hE0;
      3'd3:    reset_entry = 8'h92;
      3'd4:    reset_entry = 8'h80;
      3'd5:    reset_entry = 8'h1F;
      3'd6:    reset_entry = 8'hE3;
      default: reset_entry = 8'h00;
    endcase
  endfunction

  assign wr_ready = (state_q != S_COPY);
  assign pending  = (state_q != S_IDLE);

  // A commit seen during COPY is remembered so the next vblank re-applies the shadow set.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    commit_d = commit_q;
    case (state_q)
      S_IDLE: begin
        if (commit) state_d = S_PENDING;
      end
      S_PENDING: begin
        if (frame_start) begin
          state_d  = S_COPY;
          idx_d    = 3'd0;
          commit_d = 1'b0;
        end
      end
      S_COPY: begin
        idx_d = idx_q + 3'd1;
        if (commit) commit_d = 1'b1;
        if (idx_q == 3'd7) begin
          state_d  = (commit_q || commit) ? S_PENDING : S_IDLE;
          commit_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        idx_d    = 3'd0;
        commit_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      commit_q <= commit_d;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= reset_entry(3'(i));
        active_q[i] <= reset_entry(3'(i));
      end
    end else begin
      if (wr_en && wr_ready) shadow_q[wr_addr] <= wr_data;
      if (state_q == S_COPY) active_q[idx_q] <= shadow_q[idx_q];
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_start) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = 8'd0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // Icon colours sit at entries 4..6; a blinking icon shows the wall underneath in the off phase.
  logic [1:0] icon_bit;
  logic       icon_hidden;
  logic [7:0] pixel_color;

  always_comb begin
    icon_bit    = icon - 2'd1;
    icon_hidden = blink_q && active_q[7][icon_bit];
    if ((icon != 2'd0) && !icon_hidden) pixel_color = active_q[3'(icon) + 3'd3];
    else                                pixel_color = active_q[{1'b0, wall}];
    rgb_d = video_on ? pixel_color : 8'h00;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) rgb_q <= 8'h00;
    else      rgb_q <= rgb_d;
  end

  assign red   = rgb_q[7:5];
  assign green = rgb_q[4:2];
  assign blue  = rgb_q[1:0];

endmodule

// File: tb/tb_palette_ctrl.sv
// tb/tb_palette_ctrl.sv - directed table and sequence bench for palette_ctrl
module tb_palette_ctrl;

  logic       clock = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       commit;
  logic       frame_start;
  logic       pending;
  logic       video_on;
  logic [1:0] wall;
  logic [1:0] icon;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;

  int checks = 0;
  int errors = 0;

  palette_ctrl #(.BLINK_FRAMES(2)) dut (
    .clock       (clock),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .commit      (commit),
    .frame_start (frame_start),
    .pending     (pending),
    .video_on    (video_on),
    .wall        (wall),
    .icon        (icon),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  always #20 clock = ~clock;

  typedef struct {
    string      name;
    logic       v;
    logic [1:0] w;
    logic [1:0] i;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic pix(input logic v, input logic [1:0] w, input logic [1:0] i, output logic [7:0] o);
    video_on = v;
    wall     = w;
    icon     = i;
    tick();
    o = {red, green, blue};
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run_table(input string tag);
    logic [7:0] o;
    for (int k = 0; k < 10; k++) begin
      pix(vecs[k].v, vecs[k].w, vecs[k].i, o);
      check({tag, "_", vecs[k].name}, o, vecs[k].exp);
    end
  endtask

  initial begin
    logic [7:0] o;

    vecs[0] = '{"wall0",     1'b1, 2'd0, 2'd0, 8'hFF};
    vecs[1] = '{"wall1",     1'b1, 2'd1, 2'd0, 8'h1C};
    vecs[2] = '{"wall2",     1'b1, 2'd2, 2'd0, 8'hE0};
    vecs[3] = '{"wall3",     1'b1, 2'd3, 2'd0, 8'h92};
    vecs[4] = '{"icon1",     1'b1, 2'd0, 2'd1, 8'h80};
    vecs[5] = '{"icon2",     1'b1, 2'd2, 2'd2, 8'h1F};
    vecs[6] = '{"icon3",     1'b1, 2'd1, 2'd3, 8'hE3};
    vecs[7] = '{"blank",     1'b0, 2'd2, 2'd0, 8'h00};
    vecs[8] = '{"blank_ico", 1'b0, 2'd3, 2'd2, 8'h00};
    vecs[9] = '{"wall2_b",   1'b1, 2'd2, 2'd0, 8'hE0};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    commit = 1'b0; frame_start = 1'b0; video_on = 1'b0; wall = '0; icon = '0;
    #3 rst = 1'b0;
    #1;
    check("reset_rgb", {red, green, blue}, 8'h00);
    check("reset_pending", 8'(pending), 8'h00);
    check("reset_wr_ready", 8'(wr_ready), 8'h01);
    tick();
    tick();
    rst = 1'b1;

    run_table("default");

    // shadow write alone stays invisible through idle frames
    write(3'd0, 8'h03);
    for (int f = 0; f < 3; f++) begin
      pulse_frame();
      tick();
    end
    check("idle_frames_pending", 8'(pending), 8'h00);
    pix(1'b1, 2'd0, 2'd0, o);
    check("no_commit_wall0", o, 8'hFF);
    pulse_commit();
    check("commit_pending", 8'(pending), 8'h01);
    tick();
    tick();
    pix(1'b1, 2'd0, 2'd0, o);
    check("pending_wall0_old", o, 8'hFF);
    pulse_frame();
    for (int c = 1; c < 8; c++) begin
      check($sformatf("copy_pending_c%0d", c), 8'(pending), 8'h01);
      check($sformatf("copy_wr_ready_c%0d", c), 8'(wr_ready), 8'h00);
      tick();
    end
    check("copy_pending_c8", 8'(pending), 8'h01);
    tick();
    check("copy_done_pending", 8'(pending), 8'h00);
    check("copy_done_wr_ready", 8'(wr_ready), 8'h01);
    pix(1'b1, 2'd0, 2'd0, o);
    check("applied_wall0", o, 8'h03);

    // commit and frame_start together wait for the following frame
    write(3'd1, 8'h55);
    commit = 1'b1;
    frame_start = 1'b1;
    tick();
    commit = 1'b0;
    frame_start = 1'b0;
    check("same_cycle_pending", 8'(pending), 8'h01);
    for (int c = 0; c < 10; c++) tick();
    check("same_cycle_still_pending", 8'(pending), 8'h01);
    pix(1'b1, 2'd1, 2'd0, o);
    check("same_cycle_wall1_old", o, 8'h1C);
    pulse_frame();
    for (int c = 0; c < 8; c++) tick();
    check("same_cycle_done", 8'(pending), 8'h00);
    pix(1'b1, 2'd1, 2'd0, o);
    check("same_cycle_wall1_new", o, 8'h55);

    // write dropped and commit latched during COPY
    pulse_commit();
    pulse_frame();
    tick();
    tick();
    check("mid_copy_wr_ready", 8'(wr_ready), 8'h00);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'hAA; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("copy_commit_pending", 8'(pending), 8'h01);
    check("copy_commit_wr_ready", 8'(wr_ready), 8'h01);
    tick();
    tick();
    tick();
    check("copy_commit_holds", 8'(pending), 8'h01);
    pulse_frame();
    for (int c = 0; c < 8; c++) tick();
    check("recopy_done", 8'(pending), 8'h00);
    pix(1'b1, 2'd0, 2'd1, o);
    check("dropped_write_icon1", o, 8'h80);

    // asynchronous reset in the middle of a copy
    write(3'd2, 8'h11);
    pulse_commit();
    video_on = 1'b1; wall = 2'd0; icon = 2'd0;
    pulse_frame();
    tick();
    tick();
    tick();
    check("pre_reset_rgb", {red, green, blue}, 8'h03);
    check("pre_reset_pending", 8'(pending), 8'h01);
    #5 rst = 1'b0;
    #1;
    check("abort_rgb", {red, green, blue}, 8'h00);
    check("abort_pending", 8'(pending), 8'h00);
    check("abort_wr_ready", 8'(wr_ready), 8'h01);
    tick();
    check("abort_hold_rgb", {red, green, blue}, 8'h00);
    rst = 1'b1;
    run_table("after_abort");

    // blink on icon 1 with BLINK_FRAMES=2; upper control bits are don't-care
    write(3'd7, 8'hF9);
    pulse_commit();
    pulse_frame();
    for (int c = 0; c < 8; c++) tick();
    check("blink_apply_done", 8'(pending), 8'h00);
    pix(1'b1, 2'd2, 2'd0, o);
    check("shadow_reset_wall2", o, 8'hE0);
    pix(1'b1, 2'd3, 2'd1, o);
    check("blink_on_a", o, 8'h80);
    pulse_frame();
    pix(1'b1, 2'd3, 2'd1, o);
    check("blink_off_a", o, 8'h92);
    pix(1'b1, 2'd3, 2'd2, o);
    check("blink_icon2_off", o, 8'h1F);
    pix(1'b1, 2'd1, 2'd1, o);
    check("blink_off_wall1", o, 8'h1C);
    pulse_frame();
    pix(1'b1, 2'd3, 2'd1, o);
    check("blink_off_b", o, 8'h92);
    pulse_frame();
    pix(1'b1, 2'd3, 2'd1, o);
    check("blink_on_b", o, 8'h80);
    pix(1'b1, 2'd3, 2'd2, o);
    check("blink_icon2_on", o, 8'h1F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
